// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM button front end.
// Event codes, switch width and button indices.
package atm_pkg;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_BTN1 = 2'd1,
    EV_BTN2 = 2'd2,
    EV_BTN3 = 2'd3
  } ev_t;

  localparam int SW_W  = 4;
  localparam int BTN_N = 3;

  localparam int IDX_BTN1 = 0;
  localparam int IDX_BTN2 = 1;
  localparam int IDX_BTN3 = 2;

  // Counter width for a debounce window of d cycles, never below 1.
  function automatic int cnt_w(input int d);
    return ($clog2(d) < 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchronizer, debounced level and rise strobe.
// rise_o is combinational and marks the edge on which db goes 0->1.
module btn_debounce
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          db_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Accept the synchronized level once it has differed for the full window.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer, debounced level and window counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = db_d & ~db_q;

endmodule

// File: rtl/atm_button_conditioner.sv
// ATM button front end: debounced presses become one-cycle events
// with a switch snapshot, BTN3 > BTN2 > BTN1 priority and lockout gating.
module atm_button_conditioner
  import atm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            BTN3,
  input  logic            BTN2,
  input  logic            BTN1,
  input  logic [SW_W-1:0] SW,
  input  logic            lock,
  output logic            btn3_pulse,
  output logic            btn2_pulse,
  output logic            btn1_pulse,
  output logic [1:0]      ev_code,
  output logic [SW_W-1:0] sw_out,
  output logic            collision
);

  logic [BTN_N-1:0] rise;
  logic [BTN_N-1:0] rise_g;
  logic [SW_W-1:0]  sw_s1_q;
  logic [SW_W-1:0]  sw_s2_q;
  logic [SW_W-1:0]  sw_q;
  logic [SW_W-1:0]  sw_d;
  ev_t              ev_q;
  ev_t              ev_d;
  logic             coll_q;
  logic             coll_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
    .clk   (clk),
    .rst_n (rst),
    .btn_i (BTN1),
    .rise_o(rise[IDX_BTN1])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
    .clk   (clk),
    .rst_n (rst),
    .btn_i (BTN2),
    .rise_o(rise[IDX_BTN2])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db3 (
    .clk   (clk),
    .rst_n (rst),
    .btn_i (BTN3),
    .rise_o(rise[IDX_BTN3])
  );

  // Drop rises under lockout, then pick the single highest-priority winner.
  always_comb begin
    rise_g = lock ? '0 : rise;
    ev_d   = EV_NONE;
    priority case (1'b1)
      rise_g[IDX_BTN3]: ev_d = EV_BTN3;
      rise_g[IDX_BTN2]: ev_d = EV_BTN2;
      rise_g[IDX_BTN1]: ev_d = EV_BTN1;
      default:          ev_d = EV_NONE;
    endcase
    coll_d = $countones(rise_g) > 1;
    sw_d   = (ev_d != EV_NONE) ? sw_s2_q : sw_q;
  end

  // Switch synchronizer and registered event outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      sw_q    <= '0;
      ev_q    <= EV_NONE;
      coll_q  <= 1'b0;
    end else begin
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      sw_q    <= sw_d;
      ev_q    <= ev_d;
      coll_q  <= coll_d;
    end
  end

  assign btn3_pulse = (ev_q == EV_BTN3);
  assign btn2_pulse = (ev_q == EV_BTN2);
  assign btn1_pulse = (ev_q == EV_BTN1);
  assign ev_code    = ev_q;
  assign sw_out     = sw_q;
  assign collision  = coll_q;

endmodule

// File: tb/tb_atm_button_conditioner.sv
// Scoreboard bench for atm_button_conditioner at D=4 and D=1.
// A window-based reference model predicts every event per edge.
module tb_atm_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       BTN3 = 1'b0;
  logic       BTN2 = 1'b0;
  logic       BTN1 = 1'b0;
  logic [3:0] SW = 4'd0;
  logic       lock = 1'b0;

  logic [1:0]      p3, p2, p1, col;
  logic [1:0][1:0] ev;
  logic [1:0][3:0] so;

  always #5 clk = ~clk;

  atm_button_conditioner #(.DEBOUNCE_CYCLES(4)) u4 (
    .clk(clk), .rst(rst), .BTN3(BTN3), .BTN2(BTN2), .BTN1(BTN1),
    .SW(SW), .lock(lock),
    .btn3_pulse(p3[0]), .btn2_pulse(p2[0]), .btn1_pulse(p1[0]),
    .ev_code(ev[0]), .sw_out(so[0]), .collision(col[0])
  );

  atm_button_conditioner #(.DEBOUNCE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .BTN3(BTN3), .BTN2(BTN2), .BTN1(BTN1),
    .SW(SW), .lock(lock),
    .btn3_pulse(p3[1]), .btn2_pulse(p2[1]), .btn1_pulse(p1[1]),
    .ev_code(ev[1]), .sw_out(so[1]), .collision(col[1])
  );

  typedef struct {
    int         cyc;
    logic [1:0] code;
    logic       coll;
    logic [3:0] sw;
  } exp_t;

  exp_t       q [2][$];
  logic [2:0] rawh [$];
  logic [3:0] swh [$];
  logic [2:0] lvl [2];
  logic [3:0] last_sw [2];
  int         e = 0;
  int         cur_edge = -1;
  int         tests = 0;
  int         fails = 0;
  int         nev [2];
  int         ncoll [2];

  // True when the d raw samples feeding edge t all equal target.
  function automatic bit window_all(int d, int b, logic target, int t);
    logic v;
    for (int k = t - 1 - d; k <= t - 2; k++) begin
      v = (k < 0) ? 1'b0 : rawh[k][b];
      if (v != target) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int dval(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Reference model: predicts the event produced on each edge.
  always @(posedge clk) begin
    logic [2:0] r;
    logic [1:0] code;
    exp_t       x;
    if (!rst) begin
      rawh.delete();
      swh.delete();
      q[0].delete();
      q[1].delete();
      lvl[0] = 3'b000;
      lvl[1] = 3'b000;
      e = 0;
      cur_edge = -1;
    end else begin
      rawh.push_back({BTN3, BTN2, BTN1});
      swh.push_back(SW);
      for (int i = 0; i < 2; i++) begin
        r = 3'b000;
        for (int b = 0; b < 3; b++) begin
          if (window_all(dval(i), b, ~lvl[i][b], e)) begin
            lvl[i][b] = ~lvl[i][b];
            if (lvl[i][b]) r[b] = 1'b1;
          end
        end
        if (!lock && r != 3'b000) begin
          code = r[2] ? 2'd3 : (r[1] ? 2'd2 : 2'd1);
          x.cyc  = e;
          x.code = code;
          x.coll = $countones(r) > 1;
          x.sw   = (e >= 2) ? swh[e-2] : 4'd0;
          q[i].push_back(x);
        end
      end
      cur_edge = e;
      e++;
    end
  end

  task automatic chk(string nm, int i, logic [9:0] act, logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s D=%0d edge=%0d got=%b want=%b",
               nm, dval(i), cur_edge, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever one is due, else checks idle.
  always @(negedge clk) begin
    logic [9:0] act;
    logic [9:0] exp;
    exp_t       x;
    for (int i = 0; i < 2; i++) begin
      act = {p3[i], p2[i], p1[i], ev[i], col[i], so[i]};
      if (!rst) begin
        last_sw[i] = 4'd0;
        chk("reset", i, act, 10'd0);
      end else if (q[i].size() > 0 && q[i][0].cyc == cur_edge) begin
        x = q[i].pop_front();
        exp = {x.code == 2'd3, x.code == 2'd2, x.code == 2'd1,
               x.code, x.coll, x.sw};
        last_sw[i] = x.sw;
        nev[i]++;
        if (x.coll) ncoll[i]++;
        chk("event", i, act, exp);
      end else begin
        exp = {3'b000, 2'd0, 1'b0, last_sw[i]};
        chk("idle", i, act, exp);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(logic [2:0] m, logic [3:0] s, logic l,
                       int hold, int idle);
    {BTN3, BTN2, BTN1} = m;
    SW = s;
    lock = l;
    step(hold);
    {BTN3, BTN2, BTN1} = 3'b000;
    step(idle);
  endtask

  int hold_left [3];
  int lock_left;

  initial begin
    nev[0] = 0; nev[1] = 0; ncoll[0] = 0; ncoll[1] = 0;
    last_sw[0] = 4'd0; last_sw[1] = 4'd0;
    // Reset held with every button high, release with BTN3 still high.
    {BTN3, BTN2, BTN1} = 3'b111;
    SW = 4'b1010;
    step(4);
    {BTN2, BTN1} = 2'b00;
    rst = 1'b1;
    step(8);
    BTN3 = 1'b0;
    step(10);
    // Directed presses: clean, glitch, collision, lockout, password.
    drive(3'b100, 4'b0101, 1'b0, 6, 10);
    drive(3'b010, 4'b0011, 1'b0, 3, 10);
    drive(3'b010, 4'b0011, 1'b0, 4, 10);
    drive(3'b101, 4'b1001, 1'b0, 8, 10);
    lock = 1'b1;
    step(2);
    drive(3'b001, 4'b1111, 1'b1, 5, 10);
    lock = 1'b0;
    step(2);
    drive(3'b001, 4'b0110, 1'b0, 6, 10);
    drive(3'b100, 4'b0000, 1'b0, 1, 3);
    drive(3'b100, 4'b0000, 1'b0, 1, 3);
    drive(3'b100, 4'b0101, 1'b0, 1, 3);
    drive(3'b001, 4'b0101, 1'b0, 1, 10);
    // Reset mid-count with BTN2 held across it.
    BTN2 = 1'b1;
    step(3);
    rst = 1'b0;
    step(3);
    rst = 1'b1;
    step(8);
    BTN2 = 1'b0;
    step(10);
    // Randomized levels, switch values and lockout windows.
    for (int b = 0; b < 3; b++) hold_left[b] = 1;
    lock_left = 1;
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] m;
      m = {BTN3, BTN2, BTN1};
      for (int b = 0; b < 3; b++) begin
        hold_left[b]--;
        if (hold_left[b] == 0) begin
          m[b] = ~m[b];
          hold_left[b] = m[b] ? $urandom_range(1, 7)
                              : $urandom_range(1, 12);
        end
      end
      {BTN3, BTN2, BTN1} = m;
      lock_left--;
      if (lock_left == 0) begin
        lock = ($urandom_range(0, 3) == 0);
        lock_left = $urandom_range(1, 20);
      end
      if ($urandom_range(0, 3) == 0) SW = 4'($urandom);
      step(1);
    end
    {BTN3, BTN2, BTN1} = 3'b000;
    lock = 1'b0;
    step(20);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (q[i].size() != 0) begin
        fails++;
        $display("FAIL drain D=%0d pending=%0d want=0", dval(i), q[i].size());
      end
      tests++;
      if (nev[i] < 10) begin
        fails++;
        $display("FAIL events D=%0d seen=%0d want>=10", dval(i), nev[i]);
      end
      tests++;
      if (ncoll[i] < 1) begin
        fails++;
        $display("FAIL collisions D=%0d seen=%0d want>=1", dval(i), ncoll[i]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
